// File: rtl/seq_mul8b.sv
// Sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one WIDTH-bit add per cycle.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip RUN and finish one cycle after acceptance.
module seq_mul8b #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] shifted;
  logic               zero_bypass;

  // The adder carry-out lands in the MSB of the shifted accumulator, so nothing is lost.
  always_comb begin
    add_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
    shifted = {add_sum, acc_lo_q[WIDTH-1:1]};
  end

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_bypass = (op_a == '0) || (op_b == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          acc_hi_d = '0;
          acc_lo_d = op_b;
          cnt_d    = '0;
          if (zero_bypass) begin
            product_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_hi_d = shifted[2*WIDTH-1:WIDTH];
        acc_lo_d = shifted[WIDTH-1:0];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = shifted;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
